image_vector_streamer: RTL and testbench

Sequential front-end for the data-memory ROM: on a `start` command it walks a contiguous image region of `num_words` 32-bit words, driving the ROM's `address`/`isVector` inputs and packing each 192-bit read into a valid/ready output stream for the vector datapath. It handles partial tail vectors with a lane mask, stalls cleanly under back-pressure, and flags out-of-range requests. It sits directly upstream of the ROM (address side) and downstream of it (data side).

---
 rtl/vstream_pkg.sv | 16 +
 rtl/stream_tail_mask.sv | 37 +++
 rtl/image_vector_streamer.sv | 160 ++++++++++++++++
 tb/tb_image_vector_streamer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vstream_pkg.sv
// Shared definitions for the image vector streamer: lane count, FSM states
// and the lane-mask type used between the top and the tail-mask helper.
package vstream_pkg;

    localparam int LANES = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } vs_state_t;

    typedef logic [LANES-1:0] vs_mask_t;

endpackage

// File: rtl/stream_tail_mask.sv
// Combinational tail handling: turns the remaining word count into a lane
// mask and zeroes every ROM lane that lies beyond the end of the region.
module stream_tail_mask
    import vstream_pkg::*;
#(
    parameter int S = 32,
    parameter int V = 192
) (
    input  logic [S-1:0]     i_rem,
    input  logic [V-1:0]     i_data,
    output logic [LANES-1:0] o_mask,
    output logic [V-1:0]     o_data
);

    vs_mask_t w_mask;

    // Lane k is valid while k is still below the remaining word count.
    always_comb begin
        w_mask = '0;
        for (int k = 0; k < LANES; k++) begin
            w_mask[k] = (i_rem > S'(k));
        end
    end

    // Pass valid lanes through and force the others to zero.
    always_comb begin
        o_data = '0;
        for (int k = 0; k < LANES; k++) begin
            if (w_mask[k]) begin
                o_data[k*S +: S] = i_data[k*S +: S];
            end
        end
    end

    assign o_mask = w_mask;

endmodule

// File: rtl/image_vector_streamer.sv
// Walks a contiguous ROM region on a start command, issuing vector reads and
// packing each read into a valid/ready beat with a tail lane mask.
module image_vector_streamer
    import vstream_pkg::*;
#(
    parameter int S    = 32,
    parameter int V    = 192,
    parameter int SIZE = 30000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [S-1:0]     i_base_addr,
    input  logic [S-1:0]     i_num_words,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [S-1:0]     o_mem_address,
    output logic             o_mem_isVector,
    input  logic [V-1:0]     i_mem_rd,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [V-1:0]     o_out_data,
    output logic [LANES-1:0] o_out_mask,
    output logic             o_out_last
);

    vs_state_t        r_state;
    vs_state_t        w_next;
    logic [S-1:0]     r_cur;
    logic [S-1:0]     r_rem;
    logic             r_out_valid;
    logic [V-1:0]     r_out_data;
    logic [LANES-1:0] r_out_mask;
    logic             r_out_last;
    logic             r_err;

    logic [S:0]       w_sum;
    logic             w_over;
    logic             w_cmd_zero;
    logic             w_accept;
    logic             w_reject;
    logic             w_capture;
    logic             w_fire;
    logic             w_last_cap;
    logic [S-1:0]     w_step;
    logic [LANES-1:0] w_tail_mask;
    logic [V-1:0]     w_tail_data;

    // The range check is done one bit wider so a wrapping sum cannot sneak past.
    assign w_sum      = {1'b0, i_base_addr} + {1'b0, i_num_words};
    assign w_over     = (w_sum > (S+1)'(SIZE));
    assign w_cmd_zero = (i_num_words == '0);
    assign w_accept   = (r_state == ST_IDLE) && i_start && !w_cmd_zero && !w_over;
    assign w_reject   = (r_state == ST_IDLE) && i_start && !w_cmd_zero && w_over;

    // A new beat may be loaded whenever the output register is empty or leaving.
    assign w_fire     = r_out_valid && i_out_ready;
    assign w_capture  = (r_state == ST_FETCH) && (!r_out_valid || i_out_ready);
    assign w_last_cap = (r_rem <= S'(LANES));
    assign w_step     = w_last_cap ? r_rem : S'(LANES);

    stream_tail_mask #(
        .S (S),
        .V (V)
    ) u_tail (
        .i_rem  (r_rem),
        .i_data (i_mem_rd),
        .o_mask (w_tail_mask),
        .o_data (w_tail_data)
    );

    // State register; reset abandons any in-flight command.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus the status and ROM-address outputs.
    always_comb begin
        w_next         = r_state;
        o_busy         = 1'b0;
        o_done         = 1'b0;
        o_mem_address  = '0;
        o_mem_isVector = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (w_cmd_zero) begin
                        w_next = ST_DONE;
                    end else if (!w_over) begin
                        w_next = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                o_busy         = 1'b1;
                o_mem_address  = r_cur;
                o_mem_isVector = (r_rem > S'(1));
                if (w_capture && w_last_cap) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                o_busy = 1'b1;
                if (w_fire && r_out_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Address/remaining counters and the output beat register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cur       <= '0;
            r_rem       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_mask  <= '0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_reject;
            if (w_accept) begin
                r_cur <= i_base_addr;
                r_rem <= i_num_words;
            end else if (w_capture) begin
                r_cur <= r_cur + S'(LANES);
                r_rem <= r_rem - w_step;
            end
            if (w_capture) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_tail_data;
                r_out_mask  <= w_tail_mask;
                r_out_last  <= w_last_cap;
            end else if (w_fire) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign o_err       = r_err;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_mask  = r_out_mask;
    assign o_out_last  = r_out_last;

endmodule

// File: tb/tb_image_vector_streamer.sv
// Directed bench for image_vector_streamer with a combinational ROM model.
module tb_image_vector_streamer;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [31:0]  baseAddr;
    logic [31:0]  numWords;
    logic         busy;
    logic         done;
    logic         err;
    logic [31:0]  memAddress;
    logic         memIsVector;
    logic [191:0] memRd;
    logic         outValid;
    logic         outReady;
    logic [191:0] outData;
    logic [5:0]   outMask;
    logic         outLast;

    int total = 0;
    int bad   = 0;

    image_vector_streamer #(
        .S    (32),
        .V    (192),
        .SIZE (30000)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_base_addr    (baseAddr),
        .i_num_words    (numWords),
        .o_busy         (busy),
        .o_done         (done),
        .o_err          (err),
        .o_mem_address  (memAddress),
        .o_mem_isVector (memIsVector),
        .i_mem_rd       (memRd),
        .o_out_valid    (outValid),
        .i_out_ready    (outReady),
        .o_out_data     (outData),
        .o_out_mask     (outMask),
        .o_out_last     (outLast)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // ROM contents: every address holds a distinct recognisable word.
    function automatic logic [31:0] romWord(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[15:0]};
    endfunction

    // Combinational ROM returning six consecutive words.
    always_comb begin
        memRd = '0;
        for (int k = 0; k < 6; k++) begin
            memRd[k*32 +: 32] = romWord(memAddress + 32'(k));
        end
    end

    // Expected beat: lane k holds word idx*6+k of the region, zero past the end.
    function automatic logic [191:0] expBeat(input logic [31:0] base, input int idx, input int n);
        logic [191:0] v;
        v = '0;
        for (int k = 0; k < 6; k++) begin
            if (idx*6 + k < n) begin
                v[k*32 +: 32] = romWord(base + 32'(idx*6 + k));
            end
        end
        return v;
    endfunction

    function automatic logic [5:0] expMask(input int idx, input int n);
        logic [5:0] m;
        m = '0;
        for (int k = 0; k < 6; k++) begin
            if (idx*6 + k < n) begin
                m[k] = 1'b1;
            end
        end
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulses start for one edge with the given command.
    task automatic applyStimulus(input logic [31:0] base, input logic [31:0] n);
        baseAddr = base;
        numWords = n;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Runs a whole command with out_ready held high and checks every beat.
    task automatic runStream(input logic [31:0] base, input int n, input string tag);
        int nBeats;
        int got;
        int cycles;
        nBeats   = (n + 5) / 6;
        got      = 0;
        cycles   = 0;
        outReady = 1'b1;
        applyStimulus(base, 32'(n));
        while (got < nBeats && cycles < 100) begin
            if (outValid) begin
                checkOutput({tag, "_data"}, outData, expBeat(base, got, n));
                checkOutput({tag, "_mask"}, 192'(outMask), 192'(expMask(got, n)));
                checkOutput({tag, "_last"}, 192'(outLast), 192'(got == nBeats - 1));
                got++;
            end
            tick();
            cycles++;
        end
        checkOutput({tag, "_beats"}, 192'(got), 192'(nBeats));
        checkOutput({tag, "_done"}, 192'(done), 192'(1'b1));
        checkOutput({tag, "_busyEnd"}, 192'(busy), 192'(1'b0));
        tick();
    endtask

    // Hard stop in case the sequence ever wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        baseAddr = '0;
        numWords = '0;
        outReady = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] reset state");
        checkOutput("rst_busy",  192'(busy),     192'(1'b0));
        checkOutput("rst_valid", 192'(outValid), 192'(1'b0));
        checkOutput("rst_addr",  192'(memAddress), 192'(32'd0));
        checkOutput("rst_mask",  192'(outMask),  192'(6'd0));
        checkOutput("rst_data",  outData,        192'd0);

        $display("[TB] base=0 N=12");
        applyStimulus(32'd0, 32'd12);
        checkOutput("t1_busy",  192'(busy),        192'(1'b1));
        checkOutput("t1_addr0", 192'(memAddress),  192'(32'd0));
        checkOutput("t1_vec",   192'(memIsVector), 192'(1'b1));
        checkOutput("t1_nv",    192'(outValid),    192'(1'b0));
        tick();
        checkOutput("t1_v1",    192'(outValid),    192'(1'b1));
        checkOutput("t1_m1",    192'(outMask),     192'(6'b111111));
        checkOutput("t1_l1",    192'(outLast),     192'(1'b0));
        checkOutput("t1_d1",    outData,           expBeat(32'd0, 0, 12));
        checkOutput("t1_addr6", 192'(memAddress),  192'(32'd6));
        tick();
        checkOutput("t1_m2",    192'(outMask),     192'(6'b111111));
        checkOutput("t1_l2",    192'(outLast),     192'(1'b1));
        checkOutput("t1_d2",    outData,           expBeat(32'd0, 1, 12));
        tick();
        checkOutput("t1_done",  192'(done),        192'(1'b1));
        checkOutput("t1_busy0", 192'(busy),        192'(1'b0));
        checkOutput("t1_nv2",   192'(outValid),    192'(1'b0));
        tick();
        checkOutput("t1_done0", 192'(done),        192'(1'b0));

        $display("[TB] base=100 N=8");
        applyStimulus(32'd100, 32'd8);
        tick();
        checkOutput("t2_m1",  192'(outMask), 192'(6'b111111));
        tick();
        checkOutput("t2_m2",  192'(outMask), 192'(6'b000011));
        checkOutput("t2_hi",  192'(outData[191:64]), 192'd0);
        checkOutput("t2_lo",  192'(outData[63:0]), 192'({romWord(32'd107), romWord(32'd106)}));
        checkOutput("t2_l2",  192'(outLast), 192'(1'b1));
        tick();
        checkOutput("t2_done", 192'(done), 192'(1'b1));
        tick();

        $display("[TB] base=50 N=1");
        applyStimulus(32'd50, 32'd1);
        checkOutput("t3_vec",  192'(memIsVector), 192'(1'b0));
        checkOutput("t3_addr", 192'(memAddress),  192'(32'd50));
        tick();
        checkOutput("t3_mask", 192'(outMask), 192'(6'b000001));
        checkOutput("t3_data", outData, {160'd0, romWord(32'd50)});
        checkOutput("t3_last", 192'(outLast), 192'(1'b1));
        tick();
        checkOutput("t3_done", 192'(done), 192'(1'b1));
        tick();

        $display("[TB] base=0 N=18 with back-pressure");
        applyStimulus(32'd0, 32'd18);
        tick();
        checkOutput("t4_d1", outData, expBeat(32'd0, 0, 18));
        tick();
        checkOutput("t4_d2", outData, expBeat(32'd0, 1, 18));
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                baseAddr = 32'd500;
                numWords = 32'd6;
                start    = 1'b1;
            end
            tick();
            start = 1'b0;
            checkOutput("t4_hold_d",    outData,           expBeat(32'd0, 1, 18));
            checkOutput("t4_hold_l",    192'(outLast),     192'(1'b0));
            checkOutput("t4_hold_addr", 192'(memAddress),  192'(32'd12));
            checkOutput("t4_hold_vec",  192'(memIsVector), 192'(1'b1));
        end
        outReady = 1'b1;
        tick();
        checkOutput("t4_d3",   outData,        expBeat(32'd0, 2, 18));
        checkOutput("t4_m3",   192'(outMask),  192'(6'b111111));
        checkOutput("t4_l3",   192'(outLast),  192'(1'b1));
        tick();
        checkOutput("t4_done", 192'(done), 192'(1'b1));
        tick();

        $display("[TB] N=0 and out-of-range commands");
        applyStimulus(32'd5, 32'd0);
        checkOutput("t5_done",  192'(done),     192'(1'b1));
        checkOutput("t5_busy",  192'(busy),     192'(1'b0));
        checkOutput("t5_valid", 192'(outValid), 192'(1'b0));
        tick();
        checkOutput("t5_done0", 192'(done),     192'(1'b0));
        checkOutput("t5_valid0", 192'(outValid), 192'(1'b0));
        applyStimulus(32'd29998, 32'd5);
        checkOutput("t5_err",   192'(err),  192'(1'b1));
        checkOutput("t5_ebusy", 192'(busy), 192'(1'b0));
        tick();
        checkOutput("t5_err0",  192'(err),  192'(1'b0));
        checkOutput("t5_ebusy0", 192'(busy), 192'(1'b0));
        runStream(32'd29995, 5, "t5_edge");

        $display("[TB] reset mid-stream");
        applyStimulus(32'd300, 32'd30);
        tick();
        tick();
        checkOutput("t6_d2", outData, expBeat(32'd300, 1, 30));
        rst = 1'b1;
        #1;
        checkOutput("t6_busy",  192'(busy),        192'(1'b0));
        checkOutput("t6_valid", 192'(outValid),    192'(1'b0));
        checkOutput("t6_last",  192'(outLast),     192'(1'b0));
        checkOutput("t6_data",  outData,           192'd0);
        checkOutput("t6_mask",  192'(outMask),     192'(6'd0));
        checkOutput("t6_addr",  192'(memAddress),  192'(32'd0));
        checkOutput("t6_vec",   192'(memIsVector), 192'(1'b0));
        checkOutput("t6_done",  192'(done),        192'(1'b0));
        tick();
        rst = 1'b0;
        tick();
        runStream(32'd1000, 7, "t6_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
